// File: rtl/beep_sequencer.sv
// rtl/beep_sequencer.sv - beep pattern controller driving the tone timer (3 ticks on, 2 ticks off)
module beep_sequencer #(
  parameter int N_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic [N_W-1:0] beep_num,
  input  logic           done,
  output logic           tload,
  output logic           tsel,
  output logic           buzz,
  output logic           busy,
  output logic           fin
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N_W-1:0] rem_q, rem_d;
  logic           fin_q, fin_d;
  logic           tload_c, tsel_c;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fin_d   = 1'b0;
    tload_c = 1'b0;
    tsel_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          tload_c = 1'b1;
          tsel_c  = 1'b1;
          rem_d   = beep_num;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (done) begin
          if (rem_q == N_W'(1)) begin
            state_d = ST_IDLE;
            fin_d   = 1'b1;
          end else begin
            tload_c = 1'b1;
            state_d = ST_OFF;
            // rem == 0 means continuous mode: never decrement or wrap
            if (rem_q != '0) begin
              rem_d = rem_q - N_W'(1);
            end
          end
        end
      end
      ST_OFF: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (done) begin
          tload_c = 1'b1;
          tsel_c  = 1'b1;
          state_d = ST_ON;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      fin_q   <= fin_d;
    end
  end

  // Timer load is combinational so Timer1 reloads on the same tick; rst masks it
  assign tload = tload_c & ~rst;
  assign tsel  = tsel_c & ~rst;
  assign buzz  = (state_q == ST_ON);
  assign busy  = (state_q != ST_IDLE);
  assign fin   = fin_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// tb/tb_beep_sequencer.sv - scoreboard bench for beep_sequencer paired with a Timer1 model
module tb_beep_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] beep_num;
  logic       done;
  logic       tload, tsel, buzz, busy, fin;

  // expected vector layout: {buzz, busy, fin, tload, tsel}
  localparam logic [4:0] E_IDLE   = 5'b00000;
  localparam logic [4:0] E_START  = 5'b00011;
  localparam logic [4:0] E_ON     = 5'b11000;
  localparam logic [4:0] E_ON_END = 5'b11010;
  localparam logic [4:0] E_OFF    = 5'b01000;
  localparam logic [4:0] E_OFF_END= 5'b01011;
  localparam logic [4:0] E_FIN    = 5'b00100;

  logic [4:0] exp_q[$];
  string      tag;
  int         cyc;
  int         n_tests;
  int         n_fail;
  logic       chk_en;
  logic [1:0] tcnt;

  beep_sequencer #(.N_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .beep_num (beep_num),
    .done     (done),
    .tload    (tload),
    .tsel     (tsel),
    .buzz     (buzz),
    .busy     (busy),
    .fin      (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer1: load 2 for ON (3 ticks incl. load), 1 for OFF (2 ticks), done at zero
  always @(posedge clk) begin
    if (rst) tcnt <= 2'd0;
    else if (tload) tcnt <= tsel ? 2'd2 : 2'd1;
    else if (tcnt != 2'd0) tcnt <= tcnt - 2'd1;
  end
  assign done = (tcnt == 2'd0);

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s c%0d: scoreboard empty, got %b", tag, cyc, {buzz, busy, fin, tload, tsel});
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({buzz, busy, fin, tload, tsel} !== e) begin
          n_fail++;
          $display("FAIL %s c%0d: {buzz,busy,fin,tload,tsel} got %b expected %b",
                   tag, cyc, {buzz, busy, fin, tload, tsel}, e);
        end
      end
    end
  end

  task automatic drive_cycle(input logic s, input logic sp, input logic [3:0] bn,
                             input logic r, input logic [4:0] e);
    start    = s;
    stop     = sp;
    beep_num = bn;
    rst      = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic play_counted(input int n, input int restart_c);
    int c;
    logic s;
    cyc = 0;
    c = 0;
    drive_cycle(1'b1, 1'b0, 4'(n), 1'b0, E_START);
    c++;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 3; j++) begin
        s = (c == restart_c);
        drive_cycle(s, 1'b0, s ? 4'd7 : 4'(n), 1'b0,
                    (j == 2 && k != n - 1) ? E_ON_END : E_ON);
        c++;
      end
      if (k != n - 1) begin
        drive_cycle(1'b0, 1'b0, 4'd9, 1'b0, E_OFF);
        drive_cycle(1'b0, 1'b0, 4'd9, 1'b0, E_OFF_END);
        c += 2;
      end
    end
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b0, E_FIN);
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b0, E_IDLE);
  endtask

  task automatic test_reset;
    tag = "reset";
    cyc = 0;
    // start held during reset must not produce a timer load
    drive_cycle(1'b1, 1'b0, 4'd2, 1'b1, E_IDLE);
    drive_cycle(1'b1, 1'b0, 4'd2, 1'b1, E_IDLE);
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b0, E_IDLE);
  endtask

  task automatic test_two_beeps;
    tag = "two_beeps";
    play_counted(2, -1);
  endtask

  task automatic test_continuous;
    int p;
    logic [4:0] e;
    tag = "continuous";
    cyc = 0;
    drive_cycle(1'b1, 1'b0, 4'd0, 1'b0, E_START);
    for (int c = 1; c <= 20; c++) begin
      p = (c - 1) % 5;
      if (p < 2) e = E_ON;
      else if (p == 2) e = E_ON_END;
      else if (p == 3) e = E_OFF;
      else e = (c == 20) ? E_OFF : E_OFF_END;
      drive_cycle(1'b0, c == 20, 4'd0, 1'b0, e);
    end
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b0, E_IDLE);
    drive_cycle(1'b0, 1'b0, 4'd0, 1'b0, E_IDLE);
  endtask

  task automatic test_restart_ignored;
    tag = "restart_ignored";
    play_counted(3, 2);
  endtask

  task automatic test_reset_mid;
    tag = "reset_mid";
    cyc = 0;
    drive_cycle(1'b1, 1'b0, 4'd2, 1'b0, E_START);
    drive_cycle(1'b0, 1'b0, 4'd2, 1'b0, E_ON);
    drive_cycle(1'b0, 1'b0, 4'd2, 1'b0, E_ON);
    drive_cycle(1'b0, 1'b0, 4'd2, 1'b0, E_ON_END);
    drive_cycle(1'b0, 1'b0, 4'd2, 1'b1, E_OFF);
    drive_cycle(1'b0, 1'b0, 4'd2, 1'b0, E_IDLE);
    drive_cycle(1'b0, 1'b0, 4'd2, 1'b0, E_IDLE);
    tag = "reset_mid_restart";
    play_counted(2, -1);
  endtask

  task automatic test_start_stop;
    tag = "start_stop";
    cyc = 0;
    drive_cycle(1'b1, 1'b1, 4'd3, 1'b0, E_IDLE);
    drive_cycle(1'b0, 1'b0, 4'd3, 1'b0, E_IDLE);
    drive_cycle(1'b0, 1'b0, 4'd3, 1'b0, E_IDLE);
  endtask

  task automatic test_single;
    tag = "single";
    play_counted(1, -1);
  endtask

  task automatic test_drain;
    tag = "drain";
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    cyc      = 0;
    tag      = "init";
    rst      = 1'b1;
    start    = 1'b1;
    stop     = 1'b0;
    beep_num = 4'd2;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    test_reset;
    test_two_beeps;
    test_continuous;
    test_restart_ignored;
    test_reset_mid;
    test_start_stop;
    test_single;
    chk_en = 1'b0;
    test_drain;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
